ones_count_sequencer: RTL and testbench
=======================================

# ones_count_sequencer

Multi-cycle population-count engine that time-shares one narrow combinational chunk counter to count the set bits of a wide input word. It accepts one word through a valid/ready handshake and walks it CHUNK_W bits per clock. It accumulates the partial counts and returns the total through a valid/ready output handshake. It is the area-saving alternative to the full-width single-cycle adder-tree counters, for datapaths where throughput of one word per NCHUNK cycles is sufficient.

## Interface
Parameters:
- WORD_W, default 127: width of the counted word.
- CHUNK_W, default 7: bits counted per cycle; this is the width of the internal combinational chunk counter.

Derived (localparams, not overridable):
- NCHUNK = ceil(WORD_W / CHUNK_W), which is 19 by default.
- CNT_W = clog2(WORD_W+1), which is 7 by default.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: reset; synchronous, active-low.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word.
- in_data, input, WORD_W: word to count.
- out_valid, output, 1: out_count is valid.
- out_ready, input, 1: consumer takes out_count.
- out_count, output, CNT_W: number of 1 bits in the accepted word.
- busy, output, 1: high in COUNT and DONE.

## Operation
State machine: IDLE, COUNT, DONE.

- **IDLE**
  - in_ready=1, out_valid=0, busy=0.
  - When in_valid=1 at an edge: capture in_data into shift register sh, zero-extended to NCHUNK*CHUNK_W bits; clear acc and idx to 0; go to COUNT.
- **COUNT**
  - Each edge: acc <= acc + popcount(sh[CHUNK_W-1:0]); sh <= sh >> CHUNK_W; idx <= idx + 1.
  - When idx == NCHUNK-1 at that edge, go to DONE after the final accumulation.
  - in_ready=0.
- **DONE**
  - out_valid=1, out_count=acc, held stable until taken.
  - When out_ready=1 at an edge: go to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap of the next word with result delivery.

Rules:
- The chunk popcount is purely combinational, built from the codebase full/N-bit adder cells.
- acc is CNT_W bits and cannot overflow, because acc <= WORD_W.
- Padding bits of the last chunk are zero and contribute nothing.
- in_valid while busy is ignored: no capture, no state change.
- in_data changes after acceptance do not affect the result.
- out_ready while not in DONE is ignored.
- out_count holds the last result in IDLE, or 0 after reset; it is only meaningful while out_valid=1.

## Timing
- Reset values, applied when rst_n=0 at an edge regardless of state: state=IDLE, in_ready=1, out_valid=0, busy=0, out_count=0, acc=0, idx=0.
- Reset mid-COUNT or mid-DONE discards the word and any pending result.
- Latency: word accepted at edge E0, so out_valid=1 after edge E0+NCHUNK (after E0+19 by default).
- Throughput: one word per NCHUNK+2 cycles minimum, given out_ready=1 in DONE: one IDLE cycle plus NCHUNK COUNT cycles plus one DONE cycle.
- in_ready goes low in the cycle after acceptance and returns high the cycle after the out_valid/out_ready handshake edge.
- Backpressure: out_valid stays 1 and out_count stays constant for any number of cycles with out_ready=0.

## Configuration
- Macro: OTS_EARLY_EXIT_EN.
- **Defined:** in COUNT, the block also moves to DONE at an edge where the post-shift value (sh >> CHUNK_W) is all zero. Latency is then k cycles, where k is the index of the highest nonzero chunk plus 1, with a minimum of 1. An all-zero word gives out_valid=1 after E0+1. The result is identical to the undefined case.
- **Undefined:** latency is always exactly NCHUNK cycles, data-independent.

## Test plan
1. All ones, defaults: in_data = all ones (127 bits) accepted at E0 -> out_valid after E0+19, out_count=127.
2. Single top bit: in_data = 1<<126, so only the padded last chunk is nonzero -> out_count=1 after E0+19 in both configurations.
3. Zero word, pattern 0xAAAA…: in_data=0 -> out_count=0 after E0+19 without the macro, after E0+1 with it. Alternating pattern 0xAAAA… -> out_count=63.
4. Backpressure and ignored input: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_count unchanged. Pulse in_valid with new data during COUNT and DONE -> not accepted, result unaffected. Raise out_ready -> IDLE next edge, in_ready=1.
5. Reset mid-operation: rst_n=0 for one edge at E0+7 -> all outputs take their reset values. Then a new word 0x7F (7 ones) -> out_count=7 with normal latency.
6. Back-to-back: words 0x1, 0x3, 0x7 with in_valid and out_ready held 1 -> results 1, 2, 3 in order, each word NCHUNK+2 cycles apart.

Source files
------------

// File: rtl/ones_count_sequencer_if.sv
// Valid/ready word-in / count-out handshake bundle for ones_count_sequencer.
// master drives words and consumes counts; slave is the counting engine.
interface ones_count_sequencer_if #(
    parameter int unsigned WORD_W = 127
);
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count
    );
endinterface

// File: rtl/ones_count_sequencer.sv
// Multi-cycle popcount: walks a captured word CHUNK_W bits per clock through one chunk counter.
// Optional macro OTS_EARLY_EXIT_EN: finish as soon as the remaining shifted word is all zero.
module ones_count_sequencer #(
    parameter int unsigned WORD_W  = 127,
    parameter int unsigned CHUNK_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ones_count_sequencer_if.slave  bus,
    output logic                   busy
);

    localparam int unsigned NCHUNK = (WORD_W + CHUNK_W - 1) / CHUNK_W;
    localparam int unsigned SH_W   = NCHUNK * CHUNK_W;
    localparam int unsigned CNT_W  = $clog2(WORD_W + 1);
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e            state_q, state_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [SH_W-1:0]   sh_next;
    logic [CNT_W-1:0]  chunk_cnt;
    logic              last_chunk;
    logic              in_rdy;
    logic              out_vld;

    // Shared chunk counter: a ripple of single-bit increments over the low chunk.
    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < int'(CHUNK_W); i++) begin
            chunk_cnt = chunk_cnt + CNT_W'(sh_q[i]);
        end
    end

    assign sh_next = sh_q >> CHUNK_W;

`ifdef OTS_EARLY_EXIT_EN
    assign last_chunk = (idx_q == LAST_IDX) || (sh_next == '0);
`else
    assign last_chunk = (idx_q == LAST_IDX);
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    sh_d    = SH_W'(bus.in_data);
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StCount;
                end
            end
            StCount: begin
                busy  = 1'b1;
                acc_d = acc_q + chunk_cnt;
                sh_d  = sh_next;
                idx_d = idx_q + IDX_W'(1);
                if (last_chunk) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sh_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // acc is left untouched in IDLE, so the last result stays visible there.
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_count = acc_q;

endmodule

// File: tb/tb_ones_count_sequencer.sv
// Randomised self-checking bench for ones_count_sequencer against a popcount/latency model.
// Honours OTS_EARLY_EXIT_EN in the same way as the design when predicting latency.
module tb_ones_count_sequencer;

    localparam int unsigned WORD_W  = 127;
    localparam int unsigned CHUNK_W = 7;
    localparam int unsigned NCHUNK  = 19;
    localparam int unsigned CNT_W   = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    ones_count_sequencer_if #(.WORD_W(WORD_W)) bus ();

    ones_count_sequencer #(
        .WORD_W  (WORD_W),
        .CHUNK_W (CHUNK_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [WORD_W-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[WORD_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] exp_count(input logic [WORD_W-1:0] w);
        return CNT_W'($countones(w));
    endfunction

    // Cycles from acceptance edge to the edge after which out_valid is high.
    function automatic int exp_lat(input logic [WORD_W-1:0] w);
`ifdef OTS_EARLY_EXIT_EN
        int k;
        k = 1;
        for (int c = 0; c < int'(NCHUNK); c++) begin
            if ((w >> (c * CHUNK_W)) != '0) k = c + 1;
        end
        return k;
`else
        return NCHUNK;
`endif
    endfunction

    // Presents w from a negedge, then waits (bounded) for out_valid. lat=0 means timeout.
    task automatic run_word(input logic [WORD_W-1:0] w, input bit noise,
                            output int lat, output logic [CNT_W-1:0] cnt);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = rand_word();
        lat = 0;
        cnt = '0;
        for (int n = 1; n <= 200; n++) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = rand_word();
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                lat = n;
                cnt = bus.out_count;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags: got rdy/vld/busy=%b, required 100",
                     {bus.in_ready, bus.out_valid, busy});
        end
        n_cmp++;
        if (bus.out_count !== '0) begin
            n_err++;
            $display("FAIL reset_count: got %0d, required 0", bus.out_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_patterns();
        logic [WORD_W-1:0] pats[4];
        logic [CNT_W-1:0]  cnt;
        int                lat;
        pats[0] = '1;
        pats[1] = '0;
        pats[1][WORD_W-1] = 1'b1;
        pats[2] = '0;
        pats[3] = '0;
        for (int i = 1; i < int'(WORD_W); i += 2) pats[3][i] = 1'b1;
        for (int p = 0; p < 4; p++) begin
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL pat%0d_ready: got %b, required 1", p, bus.in_ready);
            end
            run_word(pats[p], 1'b0, lat, cnt);
            n_cmp++;
            if (lat != exp_lat(pats[p])) begin
                n_err++;
                $display("FAIL pat%0d_latency: got %0d, required %0d", p, lat, exp_lat(pats[p]));
            end
            n_cmp++;
            if (cnt !== exp_count(pats[p]) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL pat%0d_count: got %0d busy=%b, required %0d busy=1",
                         p, cnt, busy, exp_count(pats[p]));
            end
            release_result();
            n_cmp++;
            if ({bus.in_ready, bus.out_valid, busy} !== 3'b100
                || bus.out_count !== exp_count(pats[p])) begin
                n_err++;
                $display("FAIL pat%0d_idle: got rdy/vld/busy=%b count=%0d, required 100 count=%0d",
                         p, {bus.in_ready, bus.out_valid, busy}, bus.out_count,
                         exp_count(pats[p]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WORD_W-1:0] w;
        logic [CNT_W-1:0]  cnt;
        int                lat;
        w = rand_word();
        run_word(w, 1'b1, lat, cnt);
        n_cmp++;
        if (lat != exp_lat(w) || cnt !== exp_count(w)) begin
            n_err++;
            $display("FAIL bp_result: got lat=%0d count=%0d, required lat=%0d count=%0d",
                     lat, cnt, exp_lat(w), exp_count(w));
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rand_word();
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_count !== exp_count(w))
            begin
                n_err++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b count=%0d, required 1 0 %0d",
                         i, bus.out_valid, bus.in_ready, bus.out_count, exp_count(w));
            end
        end
        bus.in_valid = 1'b0;
        release_result();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got rdy=%b vld=%b, required 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [WORD_W-1:0] w;
        logic [CNT_W-1:0]  cnt;
        int                lat;
        w = rand_word();
        w[WORD_W-1] = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b100 || bus.out_count !== '0) begin
            n_err++;
            $display("FAIL midreset_state: got rdy/vld/busy=%b count=%0d, required 100 count=0",
                     {bus.in_ready, bus.out_valid, busy}, bus.out_count);
        end
        w = WORD_W'(7'h7f);
        run_word(w, 1'b0, lat, cnt);
        n_cmp++;
        if (lat != exp_lat(w) || cnt !== 7'd7) begin
            n_err++;
            $display("FAIL midreset_next: got lat=%0d count=%0d, required lat=%0d count=7",
                     lat, cnt, exp_lat(w));
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [WORD_W-1:0] words[3];
        int                acc_cyc[3];
        logic [CNT_W-1:0]  res[3];
        int                nxt;
        int                nres;
        words[0] = WORD_W'(1);
        words[1] = WORD_W'(3);
        words[2] = WORD_W'(7);
        nxt  = 0;
        nres = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && nres < 3; cyc++) begin
            if (bus.out_valid) begin
                res[nres] = bus.out_count;
                nres++;
            end
            if (nxt < 3) begin
                bus.in_valid = 1'b1;
                bus.in_data  = words[nxt];
                if (bus.in_ready) begin
                    acc_cyc[nxt] = cyc;
                    nxt++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (nres != 3) begin
            n_err++;
            $display("FAIL b2b_results: got %0d results, required 3", nres);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (res[i] !== exp_count(words[i])) begin
                    n_err++;
                    $display("FAIL b2b_count%0d: got %0d, required %0d",
                             i, res[i], exp_count(words[i]));
                end
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (acc_cyc[i+1] - acc_cyc[i] != exp_lat(words[i]) + 2) begin
                    n_err++;
                    $display("FAIL b2b_spacing%0d: got %0d, required %0d",
                             i, acc_cyc[i+1] - acc_cyc[i], exp_lat(words[i]) + 2);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [WORD_W-1:0] w;
        logic [CNT_W-1:0]  cnt;
        int                lat;
        int                hold;
        for (int t = 0; t < 15; t++) begin
            w = rand_word() >> $urandom_range(0, WORD_W - 1);
            run_word(w, 1'($urandom_range(0, 1)), lat, cnt);
            n_cmp++;
            if (lat != exp_lat(w) || cnt !== exp_count(w)) begin
                n_err++;
                $display("FAIL rand%0d: got lat=%0d count=%0d, required lat=%0d count=%0d",
                         t, lat, cnt, exp_lat(w), exp_count(w));
            end
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_count !== exp_count(w)) begin
                n_err++;
                $display("FAIL rand%0d_hold: got vld=%b count=%0d, required 1 %0d",
                         t, bus.out_valid, bus.out_count, exp_count(w));
            end
            release_result();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_patterns();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
